// File: rtl/amo_reservation_tracker.sv
// amo_reservation_tracker: LR/SC reservation on one aligned granule with registered SC verdict.
// Optional expiry counter enabled by defining AMO_LR_TIMEOUT_EN.
module amo_reservation_tracker #(
    parameter int unsigned LR_WAIT           = 32,
    parameter int unsigned RESERVATION_WORDS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     lr_valid,
    input  logic [31:0]                              lr_addr,
    input  logic                                     sc_valid,
    input  logic [31:0]                              sc_addr,
    input  logic                                     snoop_valid,
    input  logic [31:0]                              snoop_addr,
    input  logic                                     flush,
    output logic                                     sc_done,
    output logic                                     sc_success,
    output logic                                     reservation_valid,
    output logic [29-$clog2(RESERVATION_WORDS):0]    reservation_granule
);
    localparam int unsigned G = $clog2(RESERVATION_WORDS);

    typedef enum logic {IDLE, RESERVED} state_t;
    state_t state;

    logic sc_match, snoop_match, cnt_live, sc_pass, unused_bits;

    assign sc_match          = sc_addr[31:2+G] == reservation_granule;
    assign snoop_match       = snoop_valid && snoop_addr[31:2+G] == reservation_granule;
    assign sc_pass           = state == RESERVED && sc_match && !flush && !snoop_match && cnt_live;
    assign reservation_valid = state == RESERVED;

`ifdef AMO_LR_TIMEOUT_EN
    localparam int unsigned CW = $clog2(LR_WAIT + 1);
    logic [CW-1:0] cnt;
    assign cnt_live    = cnt != '0;
    assign unused_bits = ^{lr_addr[1+G:0], sc_addr[1+G:0], snoop_addr[1+G:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (lr_valid && !flush && !sc_valid)
            cnt <= CW'(LR_WAIT);
        else if (state == RESERVED && cnt != '0)
            cnt <= cnt - CW'(1);
    end
`else
    assign cnt_live    = 1'b1;
    assign unused_bits = ^{lr_addr[1+G:0], sc_addr[1+G:0], snoop_addr[1+G:0], LR_WAIT[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            reservation_granule <= '0;
            sc_done             <= 1'b0;
            sc_success          <= 1'b0;
        end else begin
            sc_done    <= sc_valid;
            sc_success <= sc_valid && sc_pass;
            if (flush || sc_valid)
                state <= IDLE;
            else if (lr_valid) begin
                state               <= RESERVED;
                reservation_granule <= lr_addr[31:2+G];
            end else if (state == RESERVED && (snoop_match || !cnt_live))
                state <= IDLE;
        end
    end

    // LR and SC share one issue slot in the LSU
    assert property (@(posedge clk) disable iff (!rst_n) !(lr_valid && sc_valid));
endmodule

// File: tb/tb_amo_reservation_tracker.sv
// tb_amo_reservation_tracker: directed LR/SC/snoop/flush/timeout/reset vectors.
module tb_amo_reservation_tracker;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        lr_valid = 1'b0, sc_valid = 1'b0, snoop_valid = 1'b0, flush = 1'b0;
    logic [31:0] lr_addr = '0, sc_addr = '0, snoop_addr = '0;
    logic        sc_done, sc_success, reservation_valid;
    logic [26:0] reservation_granule;
    int          n_cmp = 0, n_bad = 0;

    amo_reservation_tracker #(.LR_WAIT(32), .RESERVATION_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lr_valid(lr_valid), .lr_addr(lr_addr),
        .sc_valid(sc_valid), .sc_addr(sc_addr),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .flush(flush),
        .sc_done(sc_done), .sc_success(sc_success),
        .reservation_valid(reservation_valid),
        .reservation_granule(reservation_granule)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lr(input logic [31:0] a);
        lr_valid = 1'b1; lr_addr = a;
        cyc();
        lr_valid = 1'b0;
    endtask

    task automatic sc(input logic [31:0] a);
        sc_valid = 1'b1; sc_addr = a;
        cyc();
        sc_valid = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_done", sc_done, 0);
        check("rst_succ", sc_success, 0);
        check("rst_rv", reservation_valid, 0);
        check("rst_gran", reservation_granule, 0);
        cyc(); rst_n = 1'b1; cyc();

        lr(32'h8000_0040);
        check("t1_rv", reservation_valid, 1);
        check("t1_gran", reservation_granule, 32'h0400_0002);
        cyc(); cyc();
        sc(32'h8000_005C);
        check("t1_done", sc_done, 1);
        check("t1_pass", sc_success, 1);
        check("t1_rv_after", reservation_valid, 0);
        sc(32'h8000_005C);
        check("t1_2nd_done", sc_done, 1);
        check("t1_2nd_fail", sc_success, 0);
        cyc();
        check("t1_done_clear", sc_done, 0);

        lr(32'h8000_0040);
        sc(32'h8000_0060);
        check("t2_done", sc_done, 1);
        check("t2_fail", sc_success, 0);
        check("t2_rv", reservation_valid, 0);

        lr(32'h8000_0040);
        snoop_valid = 1'b1; snoop_addr = 32'h8000_0044;
        cyc(); snoop_valid = 1'b0;
        check("t3a_rv", reservation_valid, 0);
        sc(32'h8000_0040);
        check("t3a_fail", sc_success, 0);

        lr(32'h8000_0040);
        snoop_valid = 1'b1; snoop_addr = 32'h8000_0080;
        cyc(); snoop_valid = 1'b0;
        check("t3b_rv", reservation_valid, 1);
        sc(32'h8000_005C);
        check("t3b_pass", sc_success, 1);

        lr(32'h8000_0040);
        snoop_valid = 1'b1; snoop_addr = 32'h8000_0044;
        sc(32'h8000_0040); snoop_valid = 1'b0;
        check("t3c_done", sc_done, 1);
        check("t3c_fail", sc_success, 0);
        check("t3c_rv", reservation_valid, 0);

`ifdef AMO_LR_TIMEOUT_EN
        lr(32'h8000_0040);
        repeat (30) cyc();
        check("t4_rv31", reservation_valid, 1);
        sc(32'h8000_0040);
        check("t4_pass31", sc_success, 1);

        lr(32'h8000_0040);
        repeat (31) cyc();
        check("t4_rv32", reservation_valid, 1);
        cyc();
        sc(32'h8000_0040);
        check("t4_fail33", sc_success, 0);
        check("t4_rv34", reservation_valid, 0);

        lr(32'h8000_0040);
        repeat (33) cyc();
        check("t4_expired", reservation_valid, 0);
`else
        lr(32'h8000_0040);
        repeat (999) cyc();
        check("t4_rv1000", reservation_valid, 1);
        sc(32'h8000_0040);
        check("t4_pass1000", sc_success, 1);
`endif

        flush = 1'b1;
        lr(32'h8000_0040); flush = 1'b0;
        check("t5_flush_lr", reservation_valid, 0);
        snoop_valid = 1'b1; snoop_addr = 32'h8000_0044;
        lr(32'h8000_0040); snoop_valid = 1'b0;
        check("t5_lr_snoop", reservation_valid, 1);
        flush = 1'b1;
        sc(32'h8000_0040); flush = 1'b0;
        check("t5_flush_sc", sc_success, 0);
        check("t5_flush_rv", reservation_valid, 0);

        lr(32'h8000_0040);
        sc_valid = 1'b1; sc_addr = 32'h8000_0040;
        @(posedge clk); #2;
        sc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_done", sc_done, 0);
        check("t6_rv", reservation_valid, 0);
        cyc(); rst_n = 1'b1; cyc();
        sc(32'h8000_0040);
        check("t6_sc_done", sc_done, 1);
        check("t6_sc_fail", sc_success, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
